// File: rtl/cdb_writeback_arbiter.sv
// CDB writeback arbiter: per-pipe result FIFOs drained onto a single common data bus
// with round-robin selection, one registered broadcast per cycle.
module cdb_writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6,
    parameter int NUM_SRC    = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic [NUM_SRC-1:0]              valid_i,
    output logic [NUM_SRC-1:0]              ready_o,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   data_i,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]    tag_i,
    input  logic [NUM_SRC-1:0]              zero_i,
    output logic                            cdb_valid_o,
    output logic [DATA_WIDTH-1:0]           cdb_data_o,
    output logic [TAG_WIDTH-1:0]            cdb_tag_o,
    output logic                            cdb_zero_o,
    output logic [$clog2(NUM_SRC)-1:0]      cdb_src_o
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = DATA_WIDTH + TAG_WIDTH + 1;

    logic [ENT_W-1:0]      r_mem  [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr [NUM_SRC];
    logic [PTR_W-1:0]      r_rptr [NUM_SRC];
    logic [CNT_W-1:0]      r_cnt  [NUM_SRC];
    logic [SRC_W-1:0]      r_rr;

    logic                  r_cdb_valid;
    logic [DATA_WIDTH-1:0] r_cdb_data;
    logic [TAG_WIDTH-1:0]  r_cdb_tag;
    logic                  r_cdb_zero;
    logic [SRC_W-1:0]      r_cdb_src;

    logic [NUM_SRC-1:0]    w_push;
    logic [NUM_SRC-1:0]    w_pop;
    logic [NUM_SRC-1:0]    w_nonempty;
    logic                  w_gnt_vld;
    logic [SRC_W-1:0]      w_gnt_idx;
    logic [ENT_W-1:0]      w_head;

    function automatic logic [SRC_W-1:0] f_wrap_inc(input logic [SRC_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return SRC_W'(s);
    endfunction

    // ready depends only on the registered count, so a same-cycle pop never opens the door
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign ready_o[k]    = r_cnt[k] < CNT_W'(FIFO_DEPTH);
        assign w_nonempty[k] = r_cnt[k] != '0;
        assign w_push[k]     = valid_i[k] & ready_o[k] & ~flush_i;
        assign w_pop[k]      = w_gnt_vld & (w_gnt_idx == SRC_W'(k)) & ~flush_i;
    end

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_rr;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_gnt_vld && w_nonempty[f_wrap_inc(r_rr, i)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = f_wrap_inc(r_rr, i);
            end
        end
    end

    assign w_head = r_mem[w_gnt_idx][r_rptr[w_gnt_idx]];

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_push[k])
                r_mem[k][r_wptr[k]] <= {zero_i[k], tag_i[k*TAG_WIDTH +: TAG_WIDTH],
                                        data_i[k*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                r_wptr[k] <= '0;
                r_rptr[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else if (flush_i) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                r_wptr[k] <= '0;
                r_rptr[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (w_push[k]) r_wptr[k] <= r_wptr[k] + PTR_W'(1);
                if (w_pop[k])  r_rptr[k] <= r_rptr[k] + PTR_W'(1);
                if (w_push[k] && !w_pop[k])      r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                else if (!w_push[k] && w_pop[k]) r_cnt[k] <= r_cnt[k] - CNT_W'(1);
            end
        end
    end

    // payload holds its last value when idle; only valid drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr        <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_data  <= '0;
            r_cdb_tag   <= '0;
            r_cdb_zero  <= 1'b0;
            r_cdb_src   <= '0;
        end else if (flush_i) begin
            r_rr        <= '0;
            r_cdb_valid <= 1'b0;
        end else if (w_gnt_vld) begin
            r_rr        <= f_wrap_inc(w_gnt_idx, 1);
            r_cdb_valid <= 1'b1;
            {r_cdb_zero, r_cdb_tag, r_cdb_data} <= w_head;
            r_cdb_src   <= w_gnt_idx;
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    assign cdb_valid_o = r_cdb_valid;
    assign cdb_data_o  = r_cdb_data;
    assign cdb_tag_o   = r_cdb_tag;
    assign cdb_zero_o  = r_cdb_zero;
    assign cdb_src_o   = r_cdb_src;

endmodule
